// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: bundles the keypad pin side and the key-vector side of
// the scanner.
//   col_in      : keypad column lines (pulled up, 0 = pressed in driven row)
//   row_out     : one-cold row drive
//   key_out     : debounced active-low key vector, bit row*4+col
//   key_changed : one-cycle pulse when key_out takes a new value
// slave  = the scanner itself, master = the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_out;
  logic        key_changed;

  modport slave  (input col_in, output row_out, key_out, key_changed);
  modport master (output col_in, input row_out, key_out, key_changed);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one row at a time, samples the
// columns through a 2-flop synchroniser, and debounces at whole-frame
// granularity. key_out only updates after DEB_FRAMES identical frames.
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   kp       : keypad_scanner_if.slave (col_in, row_out, key_out, key_changed)
module keypad_scanner #(
  parameter int SCAN_DIV   = 12000,
  parameter int DEB_FRAMES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  keypad_scanner_if.slave kp
);
  localparam int SW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
  localparam logic [SW-1:0]        DEB_MAX = SW'(DEB_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_MAX = CNT_WIDTH'(SCAN_DIV - 1);

  logic [3:0]           col_s1, col_s2;
  logic [CNT_WIDTH-1:0] div;
  logic [1:0]           row_idx, row_nxt;
  logic [3:0]           row_q;
  logic [15:0]          frame, prev, key_q, frame_full;
  logic [SW-1:0]        stable, stable_nxt;
  logic                 chg_q, slot_end, frame_end;

  assign slot_end  = (div == DIV_MAX);
  assign frame_end = slot_end && (row_idx == 2'd3);
  assign row_nxt   = row_idx + 2'd1;

  // Full frame as it will look once the row-3 columns land; only consumed
  // at frame end, when row 3 is the row being sampled.
  assign frame_full = {col_s2, frame[11:0]};

  always_comb begin
    stable_nxt = '0;
    if (frame_full == prev)
      stable_nxt = (stable == DEB_MAX) ? DEB_MAX : stable + SW'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      col_s1  <= 4'hF;
      col_s2  <= 4'hF;
      div     <= '0;
      row_idx <= 2'd0;
      row_q   <= 4'b1110;
      frame   <= 16'hFFFF;
      prev    <= 16'hFFFF;
      stable  <= '0;
      key_q   <= 16'hFFFF;
      chg_q   <= 1'b0;
    end else begin
      col_s1 <= kp.col_in;
      col_s2 <= col_s1;
      chg_q  <= 1'b0;
      if (slot_end) begin
        // Sampling at the end of the slot leaves SCAN_DIV-1 cycles of
        // settling, which swallows the synchroniser latency.
        div                         <= '0;
        frame[{row_idx, 2'b00} +: 4] <= col_s2;
        row_idx                     <= row_nxt;
        row_q                       <= ~(4'b0001 << row_nxt);
      end else begin
        div <= div + CNT_WIDTH'(1);
      end
      if (frame_end) begin
        prev   <= frame_full;
        stable <= stable_nxt;
        if (stable_nxt == DEB_MAX) begin
          key_q <= frame_full;
          chg_q <= (frame_full != key_q);
        end
      end
    end
  end

  assign kp.row_out     = row_q;
  assign kp.key_out     = key_q;
  assign kp.key_changed = chg_q;
endmodule
